// File: rtl/y86_defs.sv
// Shared Y86-64 encodings used by the memory stage: instruction codes, status codes,
// register sentinels and the M pipeline-register layout.
package y86_defs;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] val_e;
        logic [63:0] val_a;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
    } m_reg_t;

    localparam m_reg_t M_BUBBLE = '{
        stat:  SAOK,
        icode: INOP,
        cnd:   1'b0,
        val_e: 64'd0,
        val_a: 64'd0,
        dst_e: RNONE,
        dst_m: RNONE
    };

endpackage

// File: rtl/y86_dmem.sv
// Byte-addressed data memory: asynchronous 8-byte little-endian read, synchronous
// 8-byte write, and a range flag for accesses whose last byte falls off the array.
module y86_dmem #(
    parameter int DMEM_BYTES = 1024
) (
    input  logic        clk_i,
    input  logic        we,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic [63:0] rdata,
    output logic        out_of_range
);
    localparam int AW = $clog2(DMEM_BYTES);

    logic [7:0]    mem [DMEM_BYTES];
    logic [AW-1:0] base;

    assign base         = addr[AW-1:0];
    assign out_of_range = addr > 64'(DMEM_BYTES - 8);

    always_comb begin
        rdata = '0;
        for (int k = 0; k < 8; k++) begin
            rdata[8*k +: 8] = mem[base + AW'(k)];
        end
    end

    // Callers must only raise we for in-range addresses, so base+k never wraps.
    always_ff @(posedge clk_i) begin
        if (we) begin
            for (int k = 0; k < 8; k++) begin
                mem[base + AW'(k)] <= wdata[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/memory_pipe.sv
// Y86-64 memory stage: M pipeline register, load/store control and the data memory.
// Stores fire once, on the first edge after entering M, even if the stage is stalled.
module memory_pipe
    import y86_defs::*;
#(
    parameter int DMEM_BYTES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        M_stall_i,
    input  logic        M_bubble_i,
    input  logic [2:0]  e_stat_i,
    input  logic [3:0]  e_icode_i,
    input  logic        e_Cnd_i,
    input  logic [63:0] e_valE_i,
    input  logic [63:0] e_valA_i,
    input  logic [3:0]  e_dstE_i,
    input  logic [3:0]  e_dstM_i,
    output logic [2:0]  M_stat_o,
    output logic [3:0]  M_icode_o,
    output logic        M_Cnd_o,
    output logic [63:0] M_valE_o,
    output logic [63:0] M_valA_o,
    output logic [3:0]  M_dstE_o,
    output logic [3:0]  M_dstM_o,
    output logic [63:0] m_valM_o,
    output logic [2:0]  m_stat_o
);
    m_reg_t      m_q;
    logic        written;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_addr;
    logic        out_of_range;
    logic        dmem_error;
    logic        we;
    logic [63:0] rdata;

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = m_q.val_e;
        case (m_q.icode)
            IMRMOVQ:               mem_read  = 1'b1;
            IPOPQ, IRET: begin
                mem_read = 1'b1;
                mem_addr = m_q.val_a;
            end
            IRMMOVQ, IPUSHQ, ICALL: mem_write = 1'b1;
            default: ;
        endcase
    end

    assign dmem_error = (mem_read | mem_write) & out_of_range;
    assign we         = mem_write & ~dmem_error & ~rst_i & ~written;

    y86_dmem #(.DMEM_BYTES(DMEM_BYTES)) u_dmem (
        .clk_i        (clk_i),
        .we           (we),
        .addr         (mem_addr),
        .wdata        (m_q.val_a),
        .rdata        (rdata),
        .out_of_range (out_of_range)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i || M_bubble_i) begin
            m_q     <= M_BUBBLE;
            written <= 1'b0;
        end else if (M_stall_i) begin
            written <= written | we;
        end else begin
            m_q.stat  <= e_stat_i;
            m_q.icode <= e_icode_i;
            m_q.cnd   <= e_Cnd_i;
            m_q.val_e <= e_valE_i;
            m_q.val_a <= e_valA_i;
            // A not-taken cmov must not update its destination.
            m_q.dst_e <= (e_icode_i == IRRMOVQ && !e_Cnd_i) ? RNONE : e_dstE_i;
            m_q.dst_m <= e_dstM_i;
            written   <= 1'b0;
        end
    end

    assign M_stat_o  = m_q.stat;
    assign M_icode_o = m_q.icode;
    assign M_Cnd_o   = m_q.cnd;
    assign M_valE_o  = m_q.val_e;
    assign M_valA_o  = m_q.val_a;
    assign M_dstE_o  = m_q.dst_e;
    assign M_dstM_o  = m_q.dst_m;
    assign m_valM_o  = (mem_read && !dmem_error) ? rdata : 64'd0;
    assign m_stat_o  = dmem_error ? SADR : m_q.stat;

endmodule

// File: tb/tb_memory_pipe.sv
// Self-checking bench for memory_pipe: directed scenarios followed by random traffic,
// all compared against a byte-array reference model of the memory stage.
module tb_memory_pipe;
    import y86_defs::*;

    localparam int DMEM_BYTES = 1024;
    localparam logic [63:0] ADDR_LIMIT = 64'(DMEM_BYTES - 8);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, bubble;
    logic [2:0]  e_stat;
    logic [3:0]  e_icode;
    logic        e_cnd;
    logic [63:0] e_val_e, e_val_a;
    logic [3:0]  e_dst_e, e_dst_m;
    logic [2:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_cnd;
    logic [63:0] M_val_e, M_val_a;
    logic [3:0]  M_dst_e, M_dst_m;
    logic [63:0] m_val_m;
    logic [2:0]  m_stat;

    memory_pipe #(.DMEM_BYTES(DMEM_BYTES)) dut (
        .clk_i(clk), .rst_i(rst), .M_stall_i(stall), .M_bubble_i(bubble),
        .e_stat_i(e_stat), .e_icode_i(e_icode), .e_Cnd_i(e_cnd),
        .e_valE_i(e_val_e), .e_valA_i(e_val_a), .e_dstE_i(e_dst_e), .e_dstM_i(e_dst_m),
        .M_stat_o(M_stat), .M_icode_o(M_icode), .M_Cnd_o(M_cnd),
        .M_valE_o(M_val_e), .M_valA_o(M_val_a), .M_dstE_o(M_dst_e), .M_dstM_o(M_dst_m),
        .m_valM_o(m_val_m), .m_stat_o(m_stat)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: the instruction currently in M plus a plain byte array.
    logic [2:0]  r_stat  = SAOK;
    logic [3:0]  r_icode = INOP;
    logic        r_cnd   = 1'b0;
    logic [63:0] r_val_e = '0, r_val_a = '0;
    logic [3:0]  r_dst_e = RNONE, r_dst_m = RNONE;
    bit          r_store_done = 1'b0;
    logic [7:0]  mm [DMEM_BYTES];

    function automatic bit is_store(input logic [3:0] ic);
        return ic == IRMMOVQ || ic == IPUSHQ || ic == ICALL;
    endfunction

    function automatic bit is_load(input logic [3:0] ic);
        return ic == IMRMOVQ || ic == IPOPQ || ic == IRET;
    endfunction

    function automatic logic [63:0] model_addr();
        return (r_icode == IPOPQ || r_icode == IRET) ? r_val_a : r_val_e;
    endfunction

    function automatic bit model_err();
        return (is_load(r_icode) || is_store(r_icode)) && (model_addr() > ADDR_LIMIT);
    endfunction

    function automatic logic [63:0] model_read();
        logic [63:0] v = '0;
        int a;
        if (!is_load(r_icode) || model_err()) return 64'd0;
        a = int'(model_addr());
        for (int k = 7; k >= 0; k--) v = (v << 8) | 64'(mm[a + k]);
        return v;
    endfunction

    task automatic compare_all();
        check("M_stat",  64'(M_stat),  64'(r_stat));
        check("M_icode", 64'(M_icode), 64'(r_icode));
        check("M_Cnd",   64'(M_cnd),   64'(r_cnd));
        check("M_valE",  M_val_e,      r_val_e);
        check("M_valA",  M_val_a,      r_val_a);
        check("M_dstE",  64'(M_dst_e), 64'(r_dst_e));
        check("M_dstM",  64'(M_dst_m), 64'(r_dst_m));
        check("m_valM",  m_val_m,      model_read());
        check("m_stat",  64'(m_stat),  64'(model_err() ? SADR : r_stat));
    endtask

    task automatic step(input bit s_rst, input bit s_bub, input bit s_stall,
                        input logic [3:0] ic, input logic cnd,
                        input logic [63:0] ve, input logic [63:0] va,
                        input logic [3:0] de, input logic [3:0] dm, input logic [2:0] st);
        rst = s_rst; bubble = s_bub; stall = s_stall;
        e_icode = ic; e_cnd = cnd; e_val_e = ve; e_val_a = va;
        e_dst_e = de; e_dst_m = dm; e_stat = st;
        @(posedge clk);
        if (!s_rst && is_store(r_icode) && !r_store_done && !model_err()) begin
            for (int k = 0; k < 8; k++) mm[int'(r_val_e) + k] = r_val_a[8*k +: 8];
        end
        if (s_rst || s_bub) begin
            r_stat = SAOK; r_icode = INOP; r_cnd = 1'b0; r_val_e = '0; r_val_a = '0;
            r_dst_e = RNONE; r_dst_m = RNONE; r_store_done = 1'b0;
        end else if (s_stall) begin
            r_store_done = 1'b1;
        end else begin
            r_stat = st; r_icode = ic; r_cnd = cnd; r_val_e = ve; r_val_a = va;
            r_dst_e = (ic == IRRMOVQ && !cnd) ? RNONE : de;
            r_dst_m = dm; r_store_done = 1'b0;
        end
        #1;
        compare_all();
    endtask

    task automatic ld(input logic [3:0] ic, input logic cnd, input logic [63:0] ve,
                      input logic [63:0] va, input logic [3:0] de);
        step(1'b0, 1'b0, 1'b0, ic, cnd, ve, va, de, RNONE, SAOK);
    endtask

    task automatic nop_stall();
        step(1'b0, 1'b0, 1'b1, IMRMOVQ, 1'b1, {$urandom, $urandom}, {$urandom, $urandom},
             4'($urandom), 4'($urandom), SINS);
    endtask

    logic [3:0] ops [12] = '{IHALT, INOP, IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ,
                             IOPQ, IJXX, ICALL, IRET, IPUSHQ, IPOPQ};

    initial begin
        step(1'b1, 1'b0, 1'b0, IRMMOVQ, 1'b1, 64'h8, 64'h1234, 4'h2, 4'h3, SHLT);
        check("reset_icode", 64'(M_icode), 64'(INOP));
        check("reset_dstE",  64'(M_dst_e), 64'(RNONE));

        for (int a = 0; a < DMEM_BYTES; a += 8) ld(IRMMOVQ, 1'b1, 64'(a), 64'd0, RNONE);
        ld(INOP, 1'b0, 0, 0, RNONE);

        ld(IRMMOVQ, 1'b1, 64'h10, 64'h1122334455667788, RNONE);
        ld(IMRMOVQ, 1'b1, 64'h10, 64'h0, RNONE);
        check("rmmov_mrmov", m_val_m, 64'h1122334455667788);
        check("byte_0x10", 64'(m_val_m[7:0]), 64'h88);
        ld(IMRMOVQ, 1'b1, 64'h11, 64'h0, RNONE);
        check("unaligned_0x11", m_val_m, 64'h0011223344556677);

        ld(IPUSHQ, 1'b1, 64'h1F8, 64'hAB, 4'h4);
        ld(IPOPQ, 1'b1, 64'h200, 64'h1F8, 4'h4);
        check("push_pop", m_val_m, 64'hAB);

        ld(IMRMOVQ, 1'b1, 64'(DMEM_BYTES - 7), 64'h0, RNONE);
        check("oob_read_stat", 64'(m_stat), 64'(SADR));
        check("oob_read_val", m_val_m, 64'h0);
        ld(IRMMOVQ, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hDEADBEEFCAFEF00D, RNONE);
        check("neg_store_stat", 64'(m_stat), 64'(SADR));
        ld(IMRMOVQ, 1'b1, 64'(DMEM_BYTES - 8), 64'h0, RNONE);
        check("neg_store_nowrite", m_val_m, 64'h0);

        ld(IRRMOVQ, 1'b0, 64'h5, 64'h5, 4'h3);
        check("cmov_not_taken", 64'(M_dst_e), 64'(RNONE));
        ld(IRRMOVQ, 1'b1, 64'h5, 64'h5, 4'h3);
        check("cmov_taken", 64'(M_dst_e), 64'h3);

        step(1'b0, 1'b1, 1'b0, IRMMOVQ, 1'b1, 64'h40, 64'h5555, RNONE, RNONE, SAOK);
        check("bubble_icode", 64'(M_icode), 64'(INOP));
        ld(IMRMOVQ, 1'b1, 64'h40, 64'h0, RNONE);
        check("bubble_nowrite", m_val_m, 64'h0);

        ld(IRMMOVQ, 1'b1, 64'h48, 64'hA5A5_0102_0304_5A5A, RNONE);
        for (int i = 0; i < 3; i++) begin
            nop_stall();
            check("stall_valE", M_val_e, 64'h48);
        end
        ld(IMRMOVQ, 1'b1, 64'h48, 64'h0, RNONE);
        check("stall_write", m_val_m, 64'hA5A5_0102_0304_5A5A);

        ld(IRMMOVQ, 1'b1, 64'h50, 64'h7777_6666_5555_4444, RNONE);
        step(1'b1, 1'b0, 1'b0, IMRMOVQ, 1'b1, 64'h10, 64'h0, 4'h1, 4'h2, SINS);
        check("rst_mstat", 64'(m_stat), 64'(SAOK));
        check("rst_icode", 64'(M_icode), 64'(INOP));
        ld(IMRMOVQ, 1'b1, 64'h50, 64'h0, RNONE);
        check("rst_nowrite", m_val_m, 64'h0);

        for (int n = 0; n < 3000; n++) begin
            logic [3:0]  ic;
            logic [63:0] addr, va;
            ic   = ops[$urandom_range(0, 11)];
            addr = ($urandom_range(0, 15) == 0) ? 64'(DMEM_BYTES - 7) + 64'($urandom_range(0, 4000))
                                               : 64'($urandom_range(0, DMEM_BYTES - 8));
            if ($urandom_range(0, 31) == 0) addr = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
            va = (ic == IPOPQ || ic == IRET) ? addr : {$urandom, $urandom};
            step($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 7) == 0, ic, 1'($urandom),
                 addr, va, 4'($urandom), 4'($urandom), 3'($urandom_range(1, 4)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
